// File: rtl/bp_dma_wormhole_arbiter.sv
// Wormhole round-robin arbiter merging num_req_p DMA ready/valid links onto one output.
// Packets are held end-to-end; optional packet counter under macro BP_DMA_ARB_PERF_EN.
module bp_dma_wormhole_arbiter #(
    parameter int num_req_p    = 4,
    parameter int flit_width_p = 64,
    parameter int len_width_p  = 4,
    parameter int len_offset_p = 0,
    localparam int lg_p        = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p-1:0]                   in_v_i,
    input  logic [num_req_p-1:0][flit_width_p-1:0] in_data_i,
    output logic [num_req_p-1:0]                   in_ready_and_o,
    output logic                                   out_v_o,
    output logic [flit_width_p-1:0]                out_data_o,
    input  logic                                   out_ready_and_i,
    output logic [lg_p-1:0]                        out_grant_o,
    output logic [31:0]                            pkt_count_o
);

    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_e;

    state_e                 state_q, state_d;
    logic [lg_p-1:0]        rr_q, rr_d;
    logic [lg_p-1:0]        grant_q, grant_d;
    logic [len_width_p-1:0] remaining_q, remaining_d;

    logic [lg_p-1:0]        scan_sel, sel, next_ptr;
    logic                   found;
    logic [len_width_p-1:0] hdr_len;
    logic                   hs, pkt_done;
    int                     idx;

    // First valid requester at or after rr_q, wrapping; falls back to rr_q.
    always_comb begin
        scan_sel = rr_q;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!found && in_v_i[idx]) begin
                found    = 1'b1;
                scan_sel = lg_p'(idx);
            end
        end
    end

    always_comb begin
        sel            = (state_q == IDLE) ? scan_sel : grant_q;
        out_v_o        = in_v_i[sel];
        out_data_o     = in_data_i[sel];
        in_ready_and_o = '0;
        in_ready_and_o[sel] = out_ready_and_i;
        out_grant_o    = sel;
        hdr_len        = out_data_o[len_offset_p +: len_width_p];
        hs             = out_v_o & out_ready_and_i;
        next_ptr       = (sel == lg_p'(num_req_p - 1)) ? '0 : sel + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        remaining_d = remaining_q;
        pkt_done    = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (hs) begin
                    if (hdr_len == '0) begin
                        state_d  = IDLE;
                        rr_d     = next_ptr;
                        pkt_done = 1'b1;
                    end else begin
                        state_d     = BURST;
                        grant_d     = sel;
                        remaining_d = hdr_len;
                    end
                end else if (out_v_o) begin
                    // Header offered but not taken: freeze the choice until it is.
                    state_d = HOLD;
                    grant_d = sel;
                end
            end
            BURST: begin
                if (hs) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == len_width_p'(1)) begin
                        state_d  = IDLE;
                        rr_d     = next_ptr;
                        pkt_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef BP_DMA_ARB_PERF_EN
    logic [31:0] pkt_count_q, pkt_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q + (pkt_done ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) pkt_count_q <= '0;
        else            pkt_count_q <= pkt_count_d;
    end

    assign pkt_count_o = pkt_count_q;
`else
    logic unused_pkt_done;
    assign unused_pkt_done = pkt_done;
    assign pkt_count_o     = '0;
`endif

endmodule
